// File: rtl/branch_predictor_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | branch_predictor_if : fetch query / ROB training / prediction bus|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface branch_predictor_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  query_valid_from_fetcher;
    logic [ADDR_WIDTH-1:0] query_pc_from_fetcher;
    logic [31:0]           query_inst_from_fetcher;
    logic                  flush_from_rob;
    logic                  enable_from_rob;
    logic                  jump_result_from_rob;
    logic [ADDR_WIDTH-1:0] inst_pos_from_rob;
    logic                  pred_valid_to_fetcher;
    logic                  pred_jump_to_fetcher;
    logic [ADDR_WIDTH-1:0] pred_next_pc_to_fetcher;
    logic [ADDR_WIDTH-1:0] pred_inst_pos_to_fetcher;

    modport master (
        output query_valid_from_fetcher, query_pc_from_fetcher, query_inst_from_fetcher,
        output flush_from_rob, enable_from_rob, jump_result_from_rob, inst_pos_from_rob,
        input  pred_valid_to_fetcher, pred_jump_to_fetcher,
        input  pred_next_pc_to_fetcher, pred_inst_pos_to_fetcher
    );

    modport slave (
        input  query_valid_from_fetcher, query_pc_from_fetcher, query_inst_from_fetcher,
        input  flush_from_rob, enable_from_rob, jump_result_from_rob, inst_pos_from_rob,
        output pred_valid_to_fetcher, pred_jump_to_fetcher,
        output pred_next_pc_to_fetcher, pred_inst_pos_to_fetcher
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | branch_predictor : 2-bit saturating BHT + JAL/branch target calc |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module branch_predictor #(
    parameter int         BHT_INDEX_BITS = 8,
    parameter int         ADDR_WIDTH     = 32,
    parameter logic [1:0] INIT_STATE     = 2'b01
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    input  wire logic          rdy_in,
    branch_predictor_if.slave  bus
);
    localparam int         BHT_ENTRIES = 1 << BHT_INDEX_BITS;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;

    logic [1:0]                bht_q [BHT_ENTRIES];
    logic                      pred_valid_q;
    logic                      pred_jump_q;
    logic [ADDR_WIDTH-1:0]     pred_next_pc_q;
    logic [ADDR_WIDTH-1:0]     pred_inst_pos_q;

    logic [31:0]               inst;
    logic [ADDR_WIDTH-1:0]     pc;
    logic [6:0]                opcode;
    logic [BHT_INDEX_BITS-1:0] query_idx;
    logic [BHT_INDEX_BITS-1:0] upd_idx;
    logic [ADDR_WIDTH-1:0]     imm_j;
    logic [ADDR_WIDTH-1:0]     imm_b;
    logic                      query_take;
    logic                      pred_jump_d;
    logic [ADDR_WIDTH-1:0]     pred_next_pc_d;
    logic [1:0]                upd_cur;
    logic [1:0]                upd_new;
    logic                      unused_pos_bits;

    assign inst      = bus.query_inst_from_fetcher;
    assign pc        = bus.query_pc_from_fetcher;
    assign opcode    = inst[6:0];
    assign query_idx = pc[BHT_INDEX_BITS+1:2];
    assign upd_idx   = bus.inst_pos_from_rob[BHT_INDEX_BITS+1:2];
    assign imm_j     = {{(ADDR_WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_b     = {{(ADDR_WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign query_take = bus.query_valid_from_fetcher && !bus.flush_from_rob;

    // Only the index bits of the committed PC select a counter; the rest are tagless.
    assign unused_pos_bits = ^{bus.inst_pos_from_rob[ADDR_WIDTH-1:BHT_INDEX_BITS+2],
                               bus.inst_pos_from_rob[1:0]};

    always_comb begin
        pred_jump_d    = 1'b0;
        pred_next_pc_d = pc + ADDR_WIDTH'(4);
        case (opcode)
            OP_JAL: begin
                pred_jump_d    = 1'b1;
                pred_next_pc_d = pc + imm_j;
            end
            OP_BRANCH: begin
                pred_jump_d = bht_q[query_idx][1];
                if (bht_q[query_idx][1]) begin
                    pred_next_pc_d = pc + imm_b;
                end
            end
            default: ;
        endcase
    end

    assign upd_cur = bht_q[upd_idx];

    always_comb begin
        upd_new = upd_cur;
        if (bus.jump_result_from_rob) begin
            if (upd_cur != 2'b11) upd_new = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_new = upd_cur - 2'd1;
        end
    end

    // Query reads the pre-update counter; a same-index commit lands after it.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= INIT_STATE;
            end
        end else if (rdy_in && bus.enable_from_rob) begin
            bht_q[upd_idx] <= upd_new;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pred_valid_q    <= 1'b0;
            pred_jump_q     <= 1'b0;
            pred_next_pc_q  <= '0;
            pred_inst_pos_q <= '0;
        end else if (rdy_in) begin
            pred_valid_q <= query_take;
            if (query_take) begin
                pred_jump_q     <= pred_jump_d;
                pred_next_pc_q  <= pred_next_pc_d;
                pred_inst_pos_q <= pc;
            end
        end
    end

    assign bus.pred_valid_to_fetcher    = pred_valid_q;
    assign bus.pred_jump_to_fetcher     = pred_jump_q;
    assign bus.pred_next_pc_to_fetcher  = pred_next_pc_q;
    assign bus.pred_inst_pos_to_fetcher = pred_inst_pos_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_branch_predictor : directed self-checking bench               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_branch_predictor;
    localparam logic [31:0] BEQ16 = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] JALM8 = 32'hFF9F_F06F;  // jal x0,-8
    localparam logic [31:0] JALP8 = 32'h0080_006F;  // jal x0,+8
    localparam logic [31:0] ADDI  = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] JALR  = 32'h0000_80E7;  // jalr x1,0(x1)

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    int          n_cmp  = 0;
    int          n_err  = 0;
    logic [65:0] got;
    logic [65:0] exp;

    branch_predictor_if #(.ADDR_WIDTH(32)) bus ();

    branch_predictor #(
        .BHT_INDEX_BITS(8),
        .ADDR_WIDTH    (32),
        .INIT_STATE    (2'b01)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [65:0] observe();
        return {bus.pred_valid_to_fetcher, bus.pred_jump_to_fetcher,
                bus.pred_next_pc_to_fetcher, bus.pred_inst_pos_to_fetcher};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        bus.query_valid_from_fetcher = 1'b0;
        bus.query_pc_from_fetcher    = 32'h0;
        bus.query_inst_from_fetcher  = 32'h0;
        bus.flush_from_rob           = 1'b0;
        bus.enable_from_rob          = 1'b0;
        bus.jump_result_from_rob     = 1'b0;
        bus.inst_pos_from_rob        = 32'h0;
    endtask

    task automatic set_query(input logic [31:0] pc, input logic [31:0] inst);
        bus.query_valid_from_fetcher = 1'b1;
        bus.query_pc_from_fetcher    = pc;
        bus.query_inst_from_fetcher  = inst;
    endtask

    task automatic set_train(input logic [31:0] pc, input logic taken);
        bus.enable_from_rob      = 1'b1;
        bus.inst_pos_from_rob    = pc;
        bus.jump_result_from_rob = taken;
    endtask

    task automatic train_n(input logic [31:0] pc, input logic taken, input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            set_train(pc, taken);
            tick();
        end
        drive_idle();
    endtask

    task automatic query_once(input logic [31:0] pc, input logic [31:0] inst);
        drive_idle();
        set_query(pc, inst);
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        set_query(32'h100, JALM8);
        tick();
        tick();
        n_cmp++; got = observe(); exp = '0;
        if (got !== exp) begin n_err++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
        rst_in = 1'b1;
        drive_idle();
    endtask

    task automatic test_beq_initial();
        query_once(32'h100, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h104, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL beq_init_not_taken: got %h expected %h", got, exp); end
        tick();
        n_cmp++; got = observe(); exp = {1'b0, 1'b0, 32'h104, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL no_query_hold: got %h expected %h", got, exp); end
    endtask

    task automatic test_saturation();
        train_n(32'h100, 1'b1, 3);
        query_once(32'h100, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h110, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL sat_high_taken: got %h expected %h", got, exp); end
        query_once(32'h500, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h510, 32'h500};
        if (got !== exp) begin n_err++; $display("FAIL alias_taken: got %h expected %h", got, exp); end
        train_n(32'h100, 1'b0, 4);
        query_once(32'h100, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h104, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL sat_low_not_taken: got %h expected %h", got, exp); end
        train_n(32'h100, 1'b1, 1);
        query_once(32'h100, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h104, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL weak_not_taken: got %h expected %h", got, exp); end
    endtask

    task automatic test_decode();
        query_once(32'h2000, JALM8);
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h1FF8, 32'h2000};
        if (got !== exp) begin n_err++; $display("FAIL jal_negative: got %h expected %h", got, exp); end
        query_once(32'h2004, ADDI);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h2008, 32'h2004};
        if (got !== exp) begin n_err++; $display("FAIL addi_seq: got %h expected %h", got, exp); end
        query_once(32'h2008, JALR);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h200C, 32'h2008};
        if (got !== exp) begin n_err++; $display("FAIL jalr_not_predicted: got %h expected %h", got, exp); end
        query_once(32'hFFFF_FFFC, JALP8);
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h4, 32'hFFFF_FFFC};
        if (got !== exp) begin n_err++; $display("FAIL jal_wrap: got %h expected %h", got, exp); end
        query_once(32'hFFFF_FFFC, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC};
        if (got !== exp) begin n_err++; $display("FAIL pc4_wrap: got %h expected %h", got, exp); end
    endtask

    task automatic test_same_cycle();
        drive_idle();
        set_query(32'h100, BEQ16);
        set_train(32'h100, 1'b1);
        tick();
        drive_idle();
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h104, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL same_cycle_no_bypass: got %h expected %h", got, exp); end
        query_once(32'h100, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h110, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL same_cycle_requery: got %h expected %h", got, exp); end
    endtask

    task automatic test_flush();
        query_once(32'h2000, JALM8);
        drive_idle();
        set_query(32'h2004, ADDI);
        bus.flush_from_rob = 1'b1;
        set_train(32'h600, 1'b1);
        #1;
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h1FF8, 32'h2000};
        if (got !== exp) begin n_err++; $display("FAIL flush_current_kept: got %h expected %h", got, exp); end
        tick();
        drive_idle();
        n_cmp++; got = observe(); exp = {1'b0, 1'b1, 32'h1FF8, 32'h2000};
        if (got !== exp) begin n_err++; $display("FAIL flush_kills_query: got %h expected %h", got, exp); end
        query_once(32'h600, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h610, 32'h600};
        if (got !== exp) begin n_err++; $display("FAIL update_during_flush: got %h expected %h", got, exp); end
    endtask

    task automatic test_freeze();
        query_once(32'h2004, ADDI);
        drive_idle();
        rdy_in = 1'b0;
        set_train(32'h300, 1'b1);
        set_query(32'h2000, JALM8);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h2008, 32'h2004};
            if (got !== exp) begin n_err++; $display("FAIL freeze_hold_%0d: got %h expected %h", i, got, exp); end
        end
        drive_idle();
        rdy_in = 1'b1;
        query_once(32'h300, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h304, 32'h300};
        if (got !== exp) begin n_err++; $display("FAIL freeze_no_update: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_mid();
        train_n(32'h100, 1'b1, 2);
        query_once(32'h100, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b1, 32'h110, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL pre_reset_taken: got %h expected %h", got, exp); end
        drive_idle();
        set_query(32'h2000, JALM8);
        rdy_in = 1'b0;
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        drive_idle();
        n_cmp++; got = observe(); exp = '0;
        if (got !== exp) begin n_err++; $display("FAIL mid_reset_outputs: got %h expected %h", got, exp); end
        query_once(32'h100, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h104, 32'h100};
        if (got !== exp) begin n_err++; $display("FAIL post_reset_counter: got %h expected %h", got, exp); end
        query_once(32'h600, BEQ16);
        n_cmp++; got = observe(); exp = {1'b1, 1'b0, 32'h604, 32'h600};
        if (got !== exp) begin n_err++; $display("FAIL post_reset_other_idx: got %h expected %h", got, exp); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_beq_initial();
        test_saturation();
        test_decode();
        test_same_cycle();
        test_flush();
        test_freeze();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
